// File: rtl/vga_timing_gen_p.sv
// rtl/vga_timing_gen_p.sv - parametrised VGA raster generator with aligned frame-buffer read pipeline
// Optional colour-bar output is enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen_p #(
  parameter int         H_ACTIVE  = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter bit         HS_POL    = 1'b0,
  parameter bit         VS_POL    = 1'b0,
  parameter int         RD_LAT    = 1,
  parameter int         SCALE_SH  = 0,
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] BG_COLOUR = 8'h00
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        CONFIG_COLOURS,
  input  logic              TEST_MODE,
  output logic              DPR_CLK,
  output logic [ADDR_W-1:0] VGA_ADDR_H,
  output logic [ADDR_W-1:0] VGA_ADDR_V,
  input  logic              VGA_DATA,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_DE,
  output logic [7:0]        VGA_COLOUR,
  output logic              FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIPE    = RD_LAT + 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int MW      = (HW > VW) ? HW : VW;
  // at least 10 bits so the colour-bar index hcnt[9:7] always exists
  localparam int CW      = (MW > 10) ? MW : 10;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]   hcnt;
  logic [CW-1:0]   vcnt;
  logic            act_c;
  logic            hs_c;
  logic            vs_c;
  logic            fs_c;
  logic [PIPE-1:0] act_p;
  logic [PIPE-1:0] hs_p;
  logic [PIPE-1:0] vs_p;
  logic [PIPE-1:0] fs_p;
  logic [7:0]      colour_nxt;

  assign DPR_CLK = CLK;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  assign act_c = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_c  = ((hcnt >= H_SS) && (hcnt < H_SE)) ? HS_POL : ~HS_POL;
  assign vs_c  = ((vcnt >= V_SS) && (vcnt < V_SE)) ? VS_POL : ~VS_POL;
  assign fs_c  = (hcnt == '0) && (vcnt == '0);

  always_ff @(posedge CLK) begin
    if (RESET || !act_c) begin
      VGA_ADDR_H <= '0;
      VGA_ADDR_V <= '0;
    end else begin
      VGA_ADDR_H <= ADDR_W'(hcnt >> SCALE_SH);
      VGA_ADDR_V <= ADDR_W'(vcnt >> SCALE_SH);
    end
  end

  // Stage PIPE-2 lines up with the returned pixel; stage PIPE-1 with the colour register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      act_p <= '0;
      hs_p  <= {PIPE{~HS_POL}};
      vs_p  <= {PIPE{~VS_POL}};
      fs_p  <= '0;
    end else begin
      act_p <= {act_p[PIPE-2:0], act_c};
      hs_p  <= {hs_p[PIPE-2:0], hs_c};
      vs_p  <= {vs_p[PIPE-2:0], vs_c};
      fs_p  <= {fs_p[PIPE-2:0], fs_c};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_p [PIPE-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < PIPE - 1; i++) bar_p[i] <= '0;
    end else begin
      bar_p[0] <= hcnt[9:7];
      for (int i = 1; i < PIPE - 1; i++) bar_p[i] <= bar_p[i-1];
    end
  end

  always_comb begin
    colour_nxt = 8'h00;
    if (act_p[PIPE-2]) begin
      if (TEST_MODE) colour_nxt = {bar_p[PIPE-2], bar_p[PIPE-2], bar_p[PIPE-2][2:1]};
      else           colour_nxt = VGA_DATA ? CONFIG_COLOURS : BG_COLOUR;
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = TEST_MODE;

  always_comb begin
    colour_nxt = 8'h00;
    if (act_p[PIPE-2]) colour_nxt = VGA_DATA ? CONFIG_COLOURS : BG_COLOUR;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) VGA_COLOUR <= 8'h00;
    else       VGA_COLOUR <= colour_nxt;
  end

  assign VGA_DE      = act_p[PIPE-1];
  assign VGA_HS      = hs_p[PIPE-1];
  assign VGA_VS      = vs_p[PIPE-1];
  assign FRAME_START = fs_p[PIPE-1];

endmodule
